fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the register-file/immediate decoder.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Presents one instruction at a time to decode with a valid/ready handshake.
- Computes the next PC from the decoder's immediate and rs1 data plus control flags: sequential, branch/JAL, or JALR.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; bits [1:0] must be 0.
IMEM_ADDR_W, 14, width of the word address driven to instruction memory.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
imem_req  out  1  fetch request; held high until ack
imem_addr  out  IMEM_ADDR_W  word address = pc[IMEM_ADDR_W+1:2]
imem_ack  in  1  memory returns data this cycle; may arrive in the same cycle as req
imem_rdata  in  32  instruction word, sampled when imem_req && imem_ack
inst  out  32  latched instruction to decoder
inst_valid  out  1  inst/pc_out are valid
inst_ready  in  1  decode/execute consumes inst this cycle
pc_out  out  32  byte PC of inst
pc_plus4  out  32  pc_out+4, used as the link value for JAL/JALR
branch_taken  in  1  conditional branch resolved taken (qualified by consume)
jal  in  1  current instruction is JAL
jalr  in  1  current instruction is JALR
imm32  in  32  sign-extended immediate from decoder
rs1_data  in  32  rs1 value from register file
fault  out  1  sticky misaligned-target fault
fault_addr  out  32  offending target address

Behaviour:
- States:
  - S_FETCH: request outstanding.
  - S_VALID: instruction held for decode.
  - S_FAULT: stopped.
- Reset (rst=0 at a clock edge):
  - pc<=RESET_PC, state<=S_FETCH, inst<=0, fault<=0, fault_addr<=0.
  - imem_req, inst_valid are forced 0 combinationally while rst=0.
- Output decode:
  - imem_req = rst && state==S_FETCH.
  - inst_valid = rst && state==S_VALID.
  - pc_out = pc.
  - pc_plus4 = pc+4.
- S_FETCH:
  - imem_addr is stable while waiting.
  - On imem_ack: inst<=imem_rdata, state<=S_VALID.
  - Without ack: remain in S_FETCH; no timeout.
- S_VALID:
  - inst and pc_out are held stable while inst_ready=0; no new request is issued.
  - Consume = inst_valid && inst_ready. On consume:
    - next_pc = jalr ? ((rs1_data+imm32) & ~32'h1) : (jal||branch_taken) ? pc+imm32 : pc+4.
    - If next_pc[1]==1: fault<=1, fault_addr<=next_pc, state<=S_FAULT, pc unchanged.
    - Else: pc<=next_pc, state<=S_FETCH.
- Control-flag priority: jalr > jal/branch_taken > sequential. Flags are ignored unless a consume occurs.
- S_FAULT: imem_req=0, inst_valid=0. Only reset exits this state.
- imem_ack outside S_FETCH is ignored; imem_rdata is not sampled.
- Arithmetic:
  - All PC math is 32-bit modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
  - Address bits above IMEM_ADDR_W+1 are dropped from imem_addr.
- Latency and throughput:
  - With same-cycle ack, one instruction every 2 cycles: FETCH→VALID→consume→FETCH.
  - inst_valid rises the cycle after ack.
- Reset mid-operation:
  - Reset during S_FETCH with ack pending discards any returned data; the first post-reset request is to RESET_PC.
  - Reset during S_VALID drops the held instruction.

Test Plan:
1. Reset: hold rst=0 two cycles, then release → imem_req=1, imem_addr=0, inst_valid=0, fault=0. Same-cycle ack of 0x0050_0093 → next cycle inst_valid=1, inst=0x0050_0093, pc_out=0, pc_plus4=4.
2. Delayed ack and backpressure:
   - ack arrives 3 cycles after req → imem_addr stays 0 throughout.
   - Then inst_ready=0 for 4 cycles → inst and pc_out stable, imem_req=0.
   - inst_ready=1 → next cycle imem_addr=1 (pc 0x4).
3. Branch taken: pc=0x10, branch_taken=1, imm32=0xFFFF_FFF0 on consume → next imem_addr=0 (pc 0x0). Same stimulus with branch_taken=0 → pc 0x14.
4. JALR:
   - Aligned: rs1_data=0x201, imm32=3, jalr=1 → pc 0x204.
   - Priority: jalr=1 and jal=1 together with rs1_data=0x100, imm32=8 → pc 0x108 (jalr wins).
5. Misaligned fault: jalr=1, rs1_data=0x103, imm32=0 → target 0x102 → fault=1, fault_addr=0x102, imem_req stays 0 for 10+ cycles; reset clears fault.
6. Wrap and mid-op reset:
   - pc=0xFFFF_FFFC sequential consume → pc 0x0.
   - Assert rst during an outstanding fetch at pc 0x40, then ack → data ignored; after release imem_addr=0.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if
//   Groups the instruction-memory request/ack channel, the decode-side
//   valid/ready channel, the next-PC control inputs and the fault report
//   of the fetch stage.
//   Modports:
//     master - the fetch unit (drives imem_req/addr, inst*, pc*, fault*)
//     slave  - the environment (memory + decoder + register file)
interface fetch_if #(
    parameter int IMEM_ADDR_W = 14
);
    logic                   imem_req;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic                   imem_ack;
    logic [31:0]            imem_rdata;
    logic [31:0]            inst;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [31:0]            pc_out;
    logic [31:0]            pc_plus4;
    logic                   branch_taken;
    logic                   jal;
    logic                   jalr;
    logic [31:0]            imm32;
    logic [31:0]            rs1_data;
    logic                   fault;
    logic [31:0]            fault_addr;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst, inst_valid,
        input  inst_ready,
        output pc_out, pc_plus4,
        input  branch_taken, jal, jalr, imm32, rs1_data,
        output fault, fault_addr
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst, inst_valid,
        output inst_ready,
        input  pc_out, pc_plus4,
        output branch_taken, jal, jalr, imm32, rs1_data,
        input  fault, fault_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the PC, requests one word at a time from
//   instruction memory, holds the returned instruction for decode and, when
//   decode consumes it, computes the next PC (sequential, branch/JAL, JALR).
//   A next PC with bit 1 set stops the unit in a sticky fault state.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous, active-low reset
//     bus  - fetch_if.master: imem req/ack, inst valid/ready, next-PC
//            controls, fault report
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;
    logic [31:0] next_pc;
    logic [31:0] jalr_sum;
    logic        consume;

    // Handshake outputs are masked by rst so nothing is requested or
    // presented during the reset cycle itself.
    assign bus.imem_req   = rst && (state == S_FETCH);
    assign bus.inst_valid = rst && (state == S_VALID);
    assign bus.imem_addr  = pc[IMEM_ADDR_W+1:2];
    assign bus.inst       = inst_q;
    assign bus.pc_out     = pc;
    assign bus.pc_plus4   = pc + 32'd4;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;

    assign consume = bus.inst_valid && bus.inst_ready;

    // JALR clears bit 0 of the sum; jalr outranks jal/branch_taken.
    always_comb begin
        jalr_sum = bus.rs1_data + bus.imm32;
        next_pc  = pc + 32'd4;
        if (bus.jalr)
            next_pc = jalr_sum & ~32'h1;
        else if (bus.jal || bus.branch_taken)
            next_pc = pc + bus.imm32;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            inst_q       <= 32'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        inst_q <= bus.imem_rdata;
                        state  <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (consume) begin
                        if (next_pc[1]) begin
                            // Misaligned target: PC keeps the faulting instruction.
                            fault_q      <= 1'b1;
                            fault_addr_q <= next_pc;
                            state        <= S_FAULT;
                        end else begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_if #(.IMEM_ADDR_W(14)) bus ();

    fetch_unit #(.RESET_PC(32'h0), .IMEM_ADDR_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.inst_ready   = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jal          = 1'b0;
        bus.jalr         = 1'b0;
        bus.imm32        = 32'h0;
        bus.rs1_data     = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] data);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
    endtask

    task automatic consume(input logic br, input logic j, input logic jr,
                           input logic [31:0] imm, input logic [31:0] rs1);
        bus.inst_ready   = 1'b1;
        bus.branch_taken = br;
        bus.jal          = j;
        bus.jalr         = jr;
        bus.imm32        = imm;
        bus.rs1_data     = rs1;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req_low got=%0h exp=0", bus.imem_req); end
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid_low got=%0h exp=0", bus.inst_valid); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%0h exp=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 14'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.inst_valid); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0h exp=0", bus.fault); end
        fetch(32'h0050_0093);
        checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0h exp=1", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0050_0093) begin failures++; $display("FAIL first_inst got=%08h exp=00500093", bus.inst); end
        checks++; if (bus.pc_out !== 32'h0) begin failures++; $display("FAIL first_pc got=%08h exp=0", bus.pc_out); end
        checks++; if (bus.pc_plus4 !== 32'h4) begin failures++; $display("FAIL first_pc4 got=%08h exp=4", bus.pc_plus4); end
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL first_req_off got=%0h exp=0", bus.imem_req); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.imem_addr !== 14'h0 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL wait_addr[%0d] got=%0h/%0h exp=0/1", i, bus.imem_addr, bus.imem_req); end
        end
        fetch(32'h1111_1111);
        // Ack held during backpressure must not overwrite the held word.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.inst !== 32'h1111_1111 || bus.pc_out !== 32'h0) begin failures++; $display("FAIL hold_inst[%0d] got=%08h/%08h exp=11111111/0", i, bus.inst, bus.pc_out); end
            checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1) begin failures++; $display("FAIL hold_hs[%0d] got=%0h/%0h exp=0/1", i, bus.imem_req, bus.inst_valid); end
        end
        clear_inputs();
        consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.imem_addr !== 14'h1 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL seq_addr got=%0h/%0h exp=1/1", bus.imem_addr, bus.imem_req); end
    endtask

    task automatic test_branch();
        // pc is 0x4 in S_FETCH; three sequential instructions reach 0x10.
        for (int i = 0; i < 3; i++) begin
            fetch(32'h13);
            consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        checks++; if (bus.pc_out !== 32'h10) begin failures++; $display("FAIL pc_0x10 got=%08h exp=10", bus.pc_out); end
        fetch(32'h13);
        consume(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
        checks++; if (bus.imem_addr !== 14'h0 || bus.pc_out !== 32'h0) begin failures++; $display("FAIL br_taken got=%0h/%08h exp=0/0", bus.imem_addr, bus.pc_out); end
        fetch(32'h13);
        consume(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        checks++; if (bus.pc_out !== 32'h10) begin failures++; $display("FAIL jal_0x10 got=%08h exp=10", bus.pc_out); end
        fetch(32'h13);
        consume(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
        checks++; if (bus.imem_addr !== 14'h5 || bus.pc_out !== 32'h14) begin failures++; $display("FAIL br_not_taken got=%0h/%08h exp=5/14", bus.imem_addr, bus.pc_out); end
    endtask

    task automatic test_jalr();
        fetch(32'h13);
        consume(1'b0, 1'b0, 1'b1, 32'h3, 32'h201);
        checks++; if (bus.pc_out !== 32'h204 || bus.imem_addr !== 14'h81) begin failures++; $display("FAIL jalr_align got=%08h/%0h exp=204/81", bus.pc_out, bus.imem_addr); end
        fetch(32'h13);
        consume(1'b0, 1'b1, 1'b1, 32'h8, 32'h100);
        checks++; if (bus.pc_out !== 32'h108 || bus.imem_addr !== 14'h42) begin failures++; $display("FAIL jalr_prio got=%08h/%0h exp=108/42", bus.pc_out, bus.imem_addr); end
    endtask

    task automatic test_fault();
        fetch(32'h13);
        consume(1'b0, 1'b0, 1'b1, 32'h0, 32'h103);
        checks++; if (bus.fault !== 1'b1 || bus.fault_addr !== 32'h102) begin failures++; $display("FAIL fault_set got=%0h/%08h exp=1/102", bus.fault, bus.fault_addr); end
        checks++; if (bus.pc_out !== 32'h108 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL fault_pc got=%08h/%0h exp=108/0", bus.pc_out, bus.inst_valid); end
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.fault !== 1'b1) begin failures++; $display("FAIL fault_stop[%0d] got=%0h/%0h/%0h exp=0/0/1", i, bus.imem_req, bus.inst_valid, bus.fault); end
        end
        do_reset();
        #1;
        checks++; if (bus.fault !== 1'b0 || bus.fault_addr !== 32'h0 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL fault_clear got=%0h/%08h/%0h exp=0/0/1", bus.fault, bus.fault_addr, bus.imem_req); end
    endtask

    task automatic test_wrap_midreset();
        fetch(32'h13);
        consume(1'b0, 1'b0, 1'b1, 32'hC, 32'hFFFF_FFF0);
        checks++; if (bus.pc_out !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0 || bus.imem_addr !== 14'h3FFF) begin failures++; $display("FAIL pc_top got=%08h/%08h/%0h exp=fffffffc/0/3fff", bus.pc_out, bus.pc_plus4, bus.imem_addr); end
        fetch(32'h13);
        consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.pc_out !== 32'h0 || bus.imem_addr !== 14'h0) begin failures++; $display("FAIL pc_wrap got=%08h/%0h exp=0/0", bus.pc_out, bus.imem_addr); end
        fetch(32'h13);
        consume(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        checks++; if (bus.imem_addr !== 14'h10 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL pc_0x40 got=%0h/%0h exp=10/1", bus.imem_addr, bus.imem_req); end
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req got=%0h exp=0", bus.imem_req); end
        step();
        step();
        rst          = 1'b1;
        bus.imem_ack = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 14'h0 || bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0) begin failures++; $display("FAIL midrst_after got=%0h/%0h/%0h/%08h exp=0/1/0/0", bus.imem_addr, bus.imem_req, bus.inst_valid, bus.inst); end
    endtask

    task automatic test_back_to_back();
        fetch(32'h0000_0013);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_0033;
        bus.inst_ready = 1'b1;
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 14'h1) begin failures++; $display("FAIL b2b_fetch got=%0h/%0h/%0h exp=1/0/1", bus.imem_req, bus.inst_valid, bus.imem_addr); end
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.pc_out !== 32'h4 || bus.inst !== 32'h33) begin failures++; $display("FAIL b2b_valid got=%0h/%08h/%08h exp=1/4/33", bus.inst_valid, bus.pc_out, bus.inst); end
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 14'h2) begin failures++; $display("FAIL b2b_next got=%0h/%0h exp=1/2", bus.imem_req, bus.imem_addr); end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_backpressure();
        test_branch();
        test_jalr();
        test_fault();
        test_wrap_midreset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
